// File: rtl/hilo_md_ctrl_if.sv
// Execute-stage request bus and HI/LO result bus of the multiply/divide sequencer.
// The execute stage is the master. The sequencer is the slave.
interface hilo_md_ctrl_if;
    logic        op_valid;
    logic        op_ready;
    logic [2:0]  op_code;
    logic [31:0] op_src1;
    logic [31:0] op_src2;
    logic        cancel;
    logic [31:0] hi_out;
    logic [31:0] lo_out;
    logic        busy;
    logic        done;
    logic        div_by_zero;

    modport master (
        output op_valid, op_code, op_src1, op_src2, cancel,
        input  op_ready, hi_out, lo_out, busy, done, div_by_zero
    );

    modport slave (
        input  op_valid, op_code, op_src1, op_src2, cancel,
        output op_ready, hi_out, lo_out, busy, done, div_by_zero
    );
endinterface

// File: rtl/hilo_md_ctrl.sv
// MIPS HI/LO register file with a fixed-latency multiplier and a 32-step restoring divider.
// Handles MULT/MULTU/DIV/DIVU/MTHI/MTLO, with cancel for exception flush.
module hilo_md_ctrl #(
    parameter int unsigned MUL_LAT = 2
) (
    input logic           i_clk,
    input logic           i_reset,
    hilo_md_ctrl_if.slave bus
);

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} state_t;
    typedef enum logic [2:0] {
        OP_MULT  = 3'b000,
        OP_MULTU = 3'b001,
        OP_DIV   = 3'b010,
        OP_DIVU  = 3'b011,
        OP_MTHI  = 3'b100,
        OP_MTLO  = 3'b101
    } op_t;

    state_t      r_state, w_state_nxt;
    logic [31:0] r_hi, r_lo;
    logic [63:0] r_prod;
    logic [4:0]  r_cnt;
    logic [31:0] r_dvd;
    logic [31:0] r_rem;
    logic [31:0] r_dvs;
    logic        r_qneg, r_rneg, r_dz;
    logic        r_done, r_dbz;

    logic        w_accept, w_mul_wr, w_div_wr, w_div_step, w_cnt_dec;
    logic        w_dz, w_s1, w_s2;
    logic [31:0] w_abs1, w_abs2;
    logic [63:0] w_prod;
    logic [32:0] w_shift, w_diff;

    assign w_dz   = (bus.op_src2 == '0);
    assign w_s1   = (bus.op_code == OP_DIV) & bus.op_src1[31];
    assign w_s2   = (bus.op_code == OP_DIV) & bus.op_src2[31];
    assign w_abs1 = w_s1 ? (32'd0 - bus.op_src1) : bus.op_src1;
    assign w_abs2 = w_s2 ? (32'd0 - bus.op_src2) : bus.op_src2;
    assign w_prod = bus.op_code[0]
                  ? ({32'd0, bus.op_src1} * {32'd0, bus.op_src2})
                  : ({{32{bus.op_src1[31]}}, bus.op_src1} * {{32{bus.op_src2[31]}}, bus.op_src2});

    // Quotient bits shift into r_dvd as the dividend bits shift out, so r_dvd ends as the quotient.
    assign w_shift = {r_rem, r_dvd[31]};
    assign w_diff  = w_shift - {1'b0, r_dvs};

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_mul_wr    = 1'b0;
        w_div_wr    = 1'b0;
        w_div_step  = 1'b0;
        w_cnt_dec   = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_accept = bus.op_valid & ~bus.cancel;
                if (w_accept) begin
                    case (bus.op_code)
                        OP_MULT, OP_MULTU: w_state_nxt = S_MUL;
                        OP_DIV, OP_DIVU:   w_state_nxt = w_dz ? S_FIX : S_DIV;
                        default:           w_state_nxt = S_IDLE;
                    endcase
                end
            end
            S_MUL: begin
                if (bus.cancel) begin
                    w_state_nxt = S_IDLE;
                end else if (r_cnt == '0) begin
                    w_mul_wr    = 1'b1;
                    w_state_nxt = S_IDLE;
                end else begin
                    w_cnt_dec = 1'b1;
                end
            end
            S_DIV: begin
                if (bus.cancel) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_div_step = 1'b1;
                    w_cnt_dec  = 1'b1;
                    if (r_cnt == '0) w_state_nxt = S_FIX;
                end
            end
            S_FIX: begin
                w_state_nxt = S_IDLE;
                if (!bus.cancel) w_div_wr = 1'b1;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= S_IDLE;
            r_hi    <= '0;
            r_lo    <= '0;
            r_prod  <= '0;
            r_cnt   <= '0;
            r_dvd   <= '0;
            r_rem   <= '0;
            r_dvs   <= '0;
            r_qneg  <= 1'b0;
            r_rneg  <= 1'b0;
            r_dz    <= 1'b0;
            r_done  <= 1'b0;
            r_dbz   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_done  <= w_mul_wr | w_div_wr;
            r_dbz   <= w_div_wr & r_dz;
            if (w_cnt_dec) r_cnt <= r_cnt - 5'd1;
            if (w_accept) begin
                case (bus.op_code)
                    OP_MTHI: r_hi <= bus.op_src1;
                    OP_MTLO: r_lo <= bus.op_src1;
                    OP_MULT, OP_MULTU: begin
                        r_prod <= w_prod;
                        r_cnt  <= 5'(MUL_LAT - 1);
                    end
                    OP_DIV, OP_DIVU: begin
                        // Divide by zero preloads the final LO/HI and skips the iterations.
                        r_dvd  <= w_dz ? '1 : w_abs1;
                        r_rem  <= w_dz ? bus.op_src1 : '0;
                        r_dvs  <= w_abs2;
                        r_qneg <= ~w_dz & (w_s1 ^ w_s2);
                        r_rneg <= ~w_dz & w_s1;
                        r_dz   <= w_dz;
                        r_cnt  <= 5'd31;
                    end
                    default: ;
                endcase
            end
            if (w_div_step) begin
                r_rem <= w_diff[32] ? w_shift[31:0] : w_diff[31:0];
                r_dvd <= {r_dvd[30:0], ~w_diff[32]};
            end
            if (w_mul_wr) begin
                r_hi <= r_prod[63:32];
                r_lo <= r_prod[31:0];
            end
            if (w_div_wr) begin
                r_lo <= r_qneg ? (32'd0 - r_dvd) : r_dvd;
                r_hi <= r_rneg ? (32'd0 - r_rem) : r_rem;
            end
        end
    end

    assign bus.op_ready    = (r_state == S_IDLE);
    assign bus.busy        = (r_state != S_IDLE);
    assign bus.hi_out      = r_hi;
    assign bus.lo_out      = r_lo;
    assign bus.done        = r_done;
    assign bus.div_by_zero = r_dbz;

endmodule

// File: tb/tb_hilo_md_ctrl.sv
// Bench for hilo_md_ctrl: two instances (MUL_LAT 1 and 2) driven identically and
// compared against an arithmetic model of HI/LO results and operation latencies.
module tb_hilo_md_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    hilo_md_ctrl_if b1 ();
    hilo_md_ctrl_if b2 ();

    hilo_md_ctrl #(.MUL_LAT(1)) u_dut1 (.i_clk(clk), .i_reset(rst), .bus(b1.slave));
    hilo_md_ctrl #(.MUL_LAT(2)) u_dut2 (.i_clk(clk), .i_reset(rst), .bus(b2.slave));

    logic        s_busy [2];
    logic        s_ready[2];
    logic        s_done [2];
    logic        s_dbz  [2];
    logic [31:0] s_hi   [2];
    logic [31:0] s_lo   [2];
    assign s_busy[0]  = b1.busy;        assign s_busy[1]  = b2.busy;
    assign s_ready[0] = b1.op_ready;    assign s_ready[1] = b2.op_ready;
    assign s_done[0]  = b1.done;        assign s_done[1]  = b2.done;
    assign s_dbz[0]   = b1.div_by_zero; assign s_dbz[1]   = b2.div_by_zero;
    assign s_hi[0]    = b1.hi_out;      assign s_hi[1]    = b2.hi_out;
    assign s_lo[0]    = b1.lo_out;      assign s_lo[1]    = b2.lo_out;

    int          n_total = 0;
    int          n_pass  = 0;
    int          lat[2]  = '{1, 2};
    logic [31:0] m_hi    = '0;
    logic [31:0] m_lo    = '0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic drive(input logic v, input logic [2:0] code, input logic [31:0] a,
                         input logic [31:0] b, input logic c);
        b1.op_valid = v; b1.op_code = code; b1.op_src1 = a; b1.op_src2 = b; b1.cancel = c;
        b2.op_valid = v; b2.op_code = code; b2.op_src1 = a; b2.op_src2 = b; b2.cancel = c;
    endtask

    task automatic chk_idle(input string tag);
        for (int i = 0; i < 2; i++) begin
            check($sformatf("%s_hilo[%0d]", tag, i), {s_hi[i], s_lo[i]}, {m_hi, m_lo});
            check($sformatf("%s_flags[%0d]", tag, i),
                  64'({s_ready[i], s_busy[i], s_done[i], s_dbz[i]}), 64'(4'b1000));
        end
    endtask

    // Architectural result of one accepted op; kind 0 = immediate, 1 = multiply, 2 = divide.
    task automatic model_op(input logic [2:0] code, input logic [31:0] a, input logic [31:0] b,
                            output logic [31:0] nh, output logic [31:0] nl,
                            output logic dz, output int kind);
        logic [63:0] p;
        longint      sa, sb, q, r;
        nh = m_hi; nl = m_lo; dz = 1'b0; kind = 0;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (code)
            3'd0: begin q = sa * sb; p = q; nh = p[63:32]; nl = p[31:0]; kind = 1; end
            3'd1: begin p = {32'd0, a} * {32'd0, b}; nh = p[63:32]; nl = p[31:0]; kind = 1; end
            3'd2, 3'd3: begin
                kind = 2;
                if (b == 32'd0) begin
                    dz = 1'b1; nl = 32'hFFFF_FFFF; nh = a;
                end else if (code == 3'd2) begin
                    q = sa / sb; r = sa % sb;
                    p = q; nl = p[31:0];
                    p = r; nh = p[31:0];
                end else begin
                    nl = a / b; nh = a % b;
                end
            end
            3'd4: nh = a;
            3'd5: nl = a;
            default: ;
        endcase
    endtask

    task automatic do_op(input string tag, input logic [2:0] code, input logic [31:0] a,
                         input logic [31:0] b);
        logic [31:0] eh, el;
        logic        edz, eb;
        int          kind;
        int          exp_n[2], first_d[2], nd[2], first_z[2], nz[2];
        model_op(code, a, b, eh, el, edz, kind);
        for (int i = 0; i < 2; i++) begin
            exp_n[i]   = (kind == 1) ? lat[i] : (kind == 2) ? (edz ? 1 : 33) : 0;
            first_d[i] = -1; nd[i] = 0; first_z[i] = -1; nz[i] = 0;
        end
        @(posedge clk); #1;
        drive(1'b1, code, a, b, 1'b0);
        @(posedge clk); #1;
        drive(1'b0, 3'($urandom), $urandom, $urandom, 1'b0);
        for (int n = 0; n < 36; n++) begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                eb = (kind != 0) && (n < exp_n[i]);
                check($sformatf("%s_busy[%0d]@%0d", tag, i, n),
                      64'({s_ready[i], s_busy[i]}), 64'({~eb, eb}));
                if (n == exp_n[i])
                    check($sformatf("%s_hilo[%0d]", tag, i), {s_hi[i], s_lo[i]}, {eh, el});
                if (s_done[i]) begin nd[i]++; if (first_d[i] < 0) first_d[i] = n; end
                if (s_dbz[i])  begin nz[i]++; if (first_z[i] < 0) first_z[i] = n; end
            end
        end
        for (int i = 0; i < 2; i++) begin
            check($sformatf("%s_ndone[%0d]", tag, i), 64'(nd[i]), 64'((kind != 0) ? 1 : 0));
            if (kind != 0)
                check($sformatf("%s_done_at[%0d]", tag, i), 64'(first_d[i]), 64'(exp_n[i]));
            check($sformatf("%s_ndbz[%0d]", tag, i), 64'(nz[i]), 64'(edz));
            if (edz)
                check($sformatf("%s_dbz_at[%0d]", tag, i), 64'(first_z[i]), 64'(first_d[i]));
        end
        m_hi = eh;
        m_lo = el;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int nd_seen;
        logic [2:0]  rc;
        logic [31:0] ra, rb;
        drive(1'b0, 3'd0, '0, '0, 1'b0);
        rst = 1'b1;
        @(posedge clk); @(posedge clk);
        @(negedge clk);
        chk_idle("reset");
        rst = 1'b0;

        // MTHI then MTLO on consecutive cycles
        @(posedge clk); #1;
        drive(1'b1, 3'd4, 32'h1234_5678, 32'h0, 1'b0);
        @(posedge clk); #1;
        drive(1'b1, 3'd5, 32'h9ABC_DEF0, 32'h0, 1'b0);
        @(negedge clk);
        m_hi = 32'h1234_5678;
        chk_idle("mthi");
        @(posedge clk); #1;
        drive(1'b0, 3'd0, '0, '0, 1'b0);
        @(negedge clk);
        m_lo = 32'h9ABC_DEF0;
        chk_idle("mtlo");

        do_op("mult",  3'd0, 32'hFFFF_FFFF, 32'd2);
        check("mult_hi_const", {32'd0, m_hi}, 64'hFFFF_FFFF);
        do_op("multu", 3'd1, 32'hFFFF_FFFF, 32'd2);
        do_op("divu_100_7", 3'd3, 32'd100, 32'd7);
        do_op("div_m7_2",   3'd2, 32'hFFFF_FFF9, 32'd2);
        do_op("div_ovf",    3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
        do_op("div_5_0",    3'd2, 32'd5, 32'd0);
        do_op("noop6",      3'd6, 32'h1111_1111, 32'h2222_2222);

        // Cancel a DIVU part-way through: HI/LO stay, no done
        do_op("preload", 3'd4, 32'hAAAA_0000, 32'd0);
        @(posedge clk); #1;
        drive(1'b1, 3'd3, 32'h0F0F_0F0F, 32'd3, 1'b0);
        @(posedge clk); #1;
        drive(1'b0, 3'd0, '0, '0, 1'b0);
        repeat (10) @(posedge clk);
        #1 drive(1'b0, 3'd0, '0, '0, 1'b1);
        @(posedge clk); #1;
        drive(1'b0, 3'd0, '0, '0, 1'b0);
        @(negedge clk);
        chk_idle("cancel_div");
        nd_seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (b1.done || b2.done) nd_seen++;
        end
        check("cancel_no_done", 64'(nd_seen), 64'(0));

        // Cancel with a request in IDLE drops it
        @(posedge clk); #1;
        drive(1'b1, 3'd5, 32'h5555_5555, 32'd0, 1'b1);
        @(posedge clk); #1;
        drive(1'b1, 3'd2, 32'd9, 32'd3, 1'b1);
        @(negedge clk);
        chk_idle("cancel_idle_mtlo");
        @(posedge clk); #1;
        drive(1'b0, 3'd0, '0, '0, 1'b0);
        @(negedge clk);
        chk_idle("cancel_idle_div");

        // Reset in the middle of a divide
        @(posedge clk); #1;
        drive(1'b1, 3'd2, 32'hDEAD_BEEF, 32'd7, 1'b0);
        @(posedge clk); #1;
        drive(1'b0, 3'd0, '0, '0, 1'b0);
        repeat (20) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        m_hi = '0;
        m_lo = '0;
        chk_idle("reset_mid");
        rst = 1'b0;
        do_op("divu_9_3", 3'd3, 32'd9, 32'd3);

        for (int k = 0; k < 24; k++) begin
            rc = 3'($urandom_range(0, 7));
            ra = ($urandom_range(0, 5) == 0) ? 32'h8000_0000 : 32'($urandom);
            case ($urandom_range(0, 3))
                0:       rb = 32'd0;
                1:       rb = 32'($urandom_range(1, 15));
                2:       rb = 32'hFFFF_FFFF;
                default: rb = 32'($urandom);
            endcase
            do_op($sformatf("rnd%0d_op%0d", k, rc), rc, ra, rb);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/hilo_md_ctrl.md
# hilo_md_ctrl

Multiply/divide sequencer with architectural HI/LO registers for the MIPS core. It accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from the execute stage through a valid/ready handshake. It runs signed or unsigned division as a 32-iteration restoring divider and multiplication as a fixed-latency product. It holds the core-visible HI/LO state, exposes busy so the pipeline stalls MFHI/MFLO until results land, and supports cancel for exception flush.

## Interface
- MUL_LAT, 2: edges from accept to HI/LO write for MULT/MULTU; legal range 1..8.
- clk  in  1  core clock; all state updates on rising edge.
- reset  in  1  reset; one clock; reset is synchronous and active-high.
- op_valid  in  1  operation request from execute stage.
- op_ready  out  1  block can accept; equals (state == IDLE).
- op_code  in  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO; 110/111 accepted as no-op.
- op_src1  in  32  rs value (multiplicand / dividend / MTHI-MTLO data).
- op_src2  in  32  rt value (multiplier / divisor).
- cancel  in  1  abort in-flight operation; HI/LO left untouched.
- hi_out  out  32  HI register.
- lo_out  out  32  LO register.
- busy  out  1  multi-cycle operation in flight; equals ~op_ready.
- done  out  1  one-cycle pulse in the cycle after HI/LO were written by MULT/DIV.
- div_by_zero  out  1  one-cycle pulse coincident with done for DIV/DIVU with op_src2 == 0.

## Operation
- States: IDLE, MUL, DIV, DIV_FIX. Accept = op_valid & op_ready & ~cancel.
- MTHI/MTLO in IDLE: write op_src1 to HI/LO at the accept edge. State stays IDLE. No done.
- MULT/MULTU: latch 64-bit product (signed or unsigned) and load down-counter with MUL_LAT-1. Go to MUL. When the counter is 0, write HI = product[63:32] and LO = product[31:0], then return to IDLE.
- DIV/DIVU with divisor != 0:
  - Latch |src1| and |src2| (raw values for DIVU). Record quotient sign = s1^s2 and remainder sign = s1 (DIV only). Load iteration counter with 31. Go to DIV.
  - Each DIV cycle: shift the 33-bit partial remainder left by one, bringing in the next dividend MSB. Trial-subtract the divisor. If the result is non-negative, keep the difference and set the quotient bit to 1. Decrement the counter. After the count-0 iteration, go to DIV_FIX.
  - DIV_FIX: negate the quotient and/or remainder per the recorded signs. Write LO = quotient and HI = remainder. Return to IDLE.
  - 0x80000000 / 0xFFFFFFFF (DIV) gives LO = 0x80000000, HI = 0 (two's-complement wrap). No flag is raised.
- Divide by zero: detected at accept. Go directly to DIV_FIX with LO = 0xFFFFFFFF and HI = op_src1. done and div_by_zero pulse together.
- cancel:
  - In MUL/DIV/DIV_FIX: state goes to IDLE at the next edge, with no HI/LO write and no done.
  - In IDLE: any simultaneous request is dropped, including MTHI/MTLO.
- op_src1/op_src2 are sampled only at accept. Changes afterwards have no effect.

## Timing
- Reset values: state IDLE, hi_out 0, lo_out 0, done 0, div_by_zero 0, busy 0, op_ready 1.
- op_ready/busy are purely state-decoded. They change in the cycle after the accept edge and in the cycle after the final write edge.
- MTHI/MTLO: new value visible on hi_out/lo_out the cycle after the accept edge. op_ready stays 1, so back-to-back accepts are legal.
- MULT/MULTU: accept at edge E. HI/LO written at edge E+MUL_LAT. done high during cycle E+MUL_LAT..E+MUL_LAT+1, and op_ready returns in that same cycle.
- DIV/DIVU, nonzero divisor: accept at E. DIV occupies edges E+1..E+32, DIV_FIX writes at edge E+33, done high in the following cycle. Total 33 edges.
- Divide by zero: write at edge E+1, done and div_by_zero in the following cycle.
- A new op may be accepted in the done cycle. An MTHI/MTLO accepted there overwrites the just-written value at the next edge.
- Reset mid-operation: the next edge forces all reset values. Any partial result is discarded.
- reset has priority over cancel, and cancel has priority over accept.

## Test plan
- Reset, then MTHI 0x12345678, then MTLO 0x9ABCDEF0 on consecutive cycles -> hi_out = 0x12345678, lo_out = 0x9ABCDEF0 with no busy; done never asserted.
- MULT 0xFFFFFFFF × 2 -> HI = 0xFFFFFFFF, LO = 0xFFFFFFFE. MULTU same operands -> HI = 0x00000001, LO = 0xFFFFFFFE. done exactly MUL_LAT edges after accept, checked for MUL_LAT = 1 and 2.
- DIVU 100 / 7 -> LO = 14, HI = 2 after 33 edges, with busy high throughout. DIV -7 / 2 -> LO = 0xFFFFFFFD, HI = 0xFFFFFFFF. DIV 0x80000000 / 0xFFFFFFFF -> LO = 0x80000000, HI = 0.
- DIV 5 / 0 -> after 1 edge LO = 0xFFFFFFFF, HI = 5, with done and div_by_zero pulsing together for one cycle.
- Preload HI = 0xAAAA0000. Issue DIVU, assert cancel at iteration 10 -> IDLE next edge, HI still 0xAAAA0000, no done. Assert cancel with op_valid in IDLE -> op dropped.
- Assert reset at DIV iteration 20 -> all outputs reach reset values after one edge. Then a DIVU 9 / 3 completes normally with LO = 3, HI = 0.
